// File: rtl/dm_regfile_bridge_if.sv
// Request/response channel between the debug module's abstract-command engine and dm_regfile_bridge.
// The master modport is the DM side and the slave modport is the bridge side.
interface dm_regfile_bridge_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [15:0]     req_regno;
    logic [XLEN-1:0] req_wdata;
    logic            req_postinc;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [2:0]      resp_err;
    logic [15:0]     next_regno;

    modport master (
        output req_valid, req_write, req_regno, req_wdata, req_postinc, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, next_regno
    );

    modport slave (
        input  req_valid, req_write, req_regno, req_wdata, req_postinc, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, next_regno
    );
endinterface

// File: rtl/dm_regfile_bridge.sv
// Checked, single-outstanding DM-to-register-file access bridge with configurable RF read latency.
// Optional feature macro: REGBRIDGE_POSTINC_EN (post-increment of next_regno on ok responses).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | ready for a request; halt and regno checks done on accept
//   S_WRITE | one-cycle rf_we pulse (suppressed for x0)
//   S_READ  | one-cycle rf_re pulse; samples rf_rdata here when RD_LAT=0
//   S_WAIT  | counts down remaining read latency, samples rf_rdata at 0
//   S_RESP  | response held stable until resp_ready
module dm_regfile_bridge #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    dm_regfile_bridge_if.slave       dm,
    input  logic                     core_halted,
    output logic                     rf_re,
    output logic                     rf_we,
    output logic [$clog2(NREGS)-1:0] rf_addr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [XLEN-1:0]          rf_rdata
);
    localparam int              AW       = $clog2(NREGS);
    localparam logic [15:0]     REG_BASE = 16'h1000;
    localparam logic [15:0]     REG_LAST = 16'(32'h1000 + NREGS - 1);
    localparam logic [2:0]      LAT_LOAD = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam logic [2:0]      ERR_OK   = 3'd0;
    localparam logic [2:0]      ERR_EXC  = 3'd2;
    localparam logic [2:0]      ERR_HALT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [2:0]      cnt;
    logic            halt_lost;
    logic            accept;
    logic            resp_load;
    logic [2:0]      resp_err_d;
    logic [XLEN-1:0] resp_rdata_d;
    logic            regno_ok;
    logic            addr_is_x0;
    logic [2:0]      read_err;
    logic [XLEN-1:0] read_data;

`ifdef REGBRIDGE_POSTINC_EN
    logic [15:0]     cap_regno;
    logic            cap_postinc;
    logic [15:0]     regno_now;

    // Error responses leave IDLE before cap_regno is loaded, so take regno from the bus then.
    assign regno_now = (state == S_IDLE) ? dm.req_regno : cap_regno;
`else
    logic            postinc_unused;

    assign postinc_unused = dm.req_postinc;
`endif

    assign regno_ok   = (dm.req_regno >= REG_BASE) && (dm.req_regno <= REG_LAST);
    assign addr_is_x0 = (rf_addr == '0);

    // A halt lost anywhere in the read window poisons the result even if it comes back.
    assign read_err   = (halt_lost || !core_halted) ? ERR_HALT : ERR_OK;
    assign read_data  = ((read_err != ERR_OK) || addr_is_x0) ? '0 : rf_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        dm.req_ready  = 1'b0;
        dm.resp_valid = 1'b0;
        rf_re         = 1'b0;
        rf_we         = 1'b0;
        accept        = 1'b0;
        resp_load     = 1'b0;
        resp_err_d    = ERR_OK;
        resp_rdata_d  = '0;
        case (state)
            S_IDLE: begin
                dm.req_ready = 1'b1;
                if (dm.req_valid) begin
                    accept = 1'b1;
                    if (!core_halted) begin
                        resp_load  = 1'b1;
                        resp_err_d = ERR_HALT;
                        state_d    = S_RESP;
                    end else if (!regno_ok) begin
                        resp_load  = 1'b1;
                        resp_err_d = ERR_EXC;
                        state_d    = S_RESP;
                    end else if (dm.req_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                rf_we     = !addr_is_x0;
                resp_load = 1'b1;
                state_d   = S_RESP;
            end
            S_READ: begin
                rf_re = 1'b1;
                if (RD_LAT == 0) begin
                    resp_load    = 1'b1;
                    resp_err_d   = read_err;
                    resp_rdata_d = read_data;
                    state_d      = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    resp_load    = 1'b1;
                    resp_err_d   = read_err;
                    resp_rdata_d = read_data;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                dm.resp_valid = 1'b1;
                if (dm.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_addr       <= '0;
            rf_wdata      <= '0;
            cnt           <= '0;
            halt_lost     <= 1'b0;
            dm.resp_rdata <= '0;
            dm.resp_err   <= ERR_OK;
            dm.next_regno <= REG_BASE;
`ifdef REGBRIDGE_POSTINC_EN
            cap_regno     <= REG_BASE;
            cap_postinc   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                halt_lost <= 1'b0;
`ifdef REGBRIDGE_POSTINC_EN
                cap_regno   <= dm.req_regno;
                cap_postinc <= dm.req_postinc;
`else
                dm.next_regno <= dm.req_regno;
`endif
                // Rejected requests must not disturb the held RF address/data.
                if (core_halted && regno_ok) begin
                    rf_addr <= dm.req_regno[AW-1:0];
                    if (dm.req_write) begin
                        rf_wdata <= dm.req_wdata;
                    end
                end
            end
            if (((state == S_READ) || (state == S_WAIT)) && !core_halted) begin
                halt_lost <= 1'b1;
            end
            if (state == S_READ) begin
                cnt <= LAT_LOAD;
            end else if ((state == S_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 3'd1;
            end
            if (resp_load) begin
                dm.resp_rdata <= resp_rdata_d;
                dm.resp_err   <= resp_err_d;
`ifdef REGBRIDGE_POSTINC_EN
                dm.next_regno <= ((resp_err_d == ERR_OK) && cap_postinc) ? cap_regno + 16'd1 : regno_now;
`endif
            end
        end
    end
endmodule

// File: tb/tb_dm_regfile_bridge.sv
// Directed bench for dm_regfile_bridge (RD_LAT=3); RF model returns valid data only RD_LAT cycles after rf_re.
// Expected next_regno values follow REGBRIDGE_POSTINC_EN when it is defined for the build.
module tb_dm_regfile_bridge;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_halted = 1'b1;
    logic        rf_re;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;

    logic [31:0] rf_mem [NREGS];
    logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic [4:0]  a1 = '0, a2 = '0, a3 = '0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [4:0]  we_addr = '0;
    logic [31:0] we_data = '0;

    int checks = 0;
    int passed = 0;

    dm_regfile_bridge_if #(.XLEN(XLEN)) bus();

    dm_regfile_bridge #(.XLEN(XLEN), .NREGS(NREGS), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .dm          (bus.slave),
        .core_halted (core_halted),
        .rf_re       (rf_re),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata)
    );

    always #5 clk = ~clk;

    // Read data is valid only in cycle (rf_re cycle + RD_LAT); garbage otherwise.
    always @(posedge clk) begin
        v1 <= rf_re;
        v2 <= v1;
        v3 <= v2;
        a1 <= rf_addr;
        a2 <= a1;
        a3 <= a2;
        if (rf_re) re_cnt <= re_cnt + 1;
        if (rf_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= rf_addr;
            we_data <= rf_wdata;
        end
    end
    assign rf_rdata = v3 ? rf_mem[a3] : 32'hBAD0_BAD0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [15:0] r, input logic [31:0] d, input logic p);
        bus.req_valid   = 1'b1;
        bus.req_write   = w;
        bus.req_regno   = r;
        bus.req_wdata   = d;
        bus.req_postinc = p;
        step();
        bus.req_valid   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); else passed++;
        checks++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); else passed++;
        checks++; if (bus.resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata got %h exp 0", bus.resp_rdata); else passed++;
        checks++; if (bus.resp_err !== 3'd0) $display("FAIL reset_resp_err got %0d exp 0", bus.resp_err); else passed++;
        checks++; if (bus.next_regno !== 16'h1000) $display("FAIL reset_next_regno got %h exp 1000", bus.next_regno); else passed++;
        checks++; if ({rf_re, rf_we} !== 2'b00) $display("FAIL reset_strobes got %b exp 00", {rf_re, rf_we}); else passed++;
        checks++; if (rf_addr !== 5'd0) $display("FAIL reset_rf_addr got %0d exp 0", rf_addr); else passed++;
        checks++; if (rf_wdata !== 32'h0) $display("FAIL reset_rf_wdata got %h exp 0", rf_wdata); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        int w0;
        w0 = we_cnt;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL wr_idle_ready got %b exp 1", bus.req_ready); else passed++;
        issue(1'b1, 16'h1005, 32'hDEAD_BEEF, 1'b0);
        checks++; if (rf_we !== 1'b1) $display("FAIL wr_rf_we got %b exp 1", rf_we); else passed++;
        checks++; if (rf_addr !== 5'd5) $display("FAIL wr_rf_addr got %0d exp 5", rf_addr); else passed++;
        checks++; if (rf_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_rf_wdata got %h exp deadbeef", rf_wdata); else passed++;
        checks++; if (bus.resp_valid !== 1'b0) $display("FAIL wr_early_resp got %b exp 0", bus.resp_valid); else passed++;
        step();
        checks++; if (rf_we !== 1'b0) $display("FAIL wr_pulse_end got %b exp 0", rf_we); else passed++;
        checks++; if (bus.resp_valid !== 1'b1) $display("FAIL wr_resp_valid got %b exp 1", bus.resp_valid); else passed++;
        checks++; if (bus.resp_err !== 3'd0 || bus.resp_rdata !== 32'h0) $display("FAIL wr_resp got err=%0d rdata=%h exp err=0 rdata=0", bus.resp_err, bus.resp_rdata); else passed++;
        checks++; if (bus.req_ready !== 1'b0) $display("FAIL wr_busy_ready got %b exp 0", bus.req_ready); else passed++;
        checks++; if (we_cnt - w0 !== 1) $display("FAIL wr_pulse_count got %0d exp 1", we_cnt - w0); else passed++;
        step();
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL wr_after_hs got ready=%b valid=%b exp 1/0", bus.req_ready, bus.resp_valid); else passed++;
    endtask

    task automatic test_read();
        int r0;
        r0 = re_cnt;
        issue(1'b0, 16'h1005, 32'h0, 1'b0);
        checks++; if (rf_re !== 1'b1 || rf_addr !== 5'd5) $display("FAIL rd_strobe got re=%b addr=%0d exp 1/5", rf_re, rf_addr); else passed++;
        repeat (3) step();
        checks++; if (bus.resp_valid !== 1'b0) $display("FAIL rd_early_resp got %b exp 0 at N+4", bus.resp_valid); else passed++;
        step();
        checks++; if (bus.resp_valid !== 1'b1) $display("FAIL rd_resp_valid got %b exp 1 at N+5", bus.resp_valid); else passed++;
        checks++; if (bus.resp_rdata !== 32'h1234_5678) $display("FAIL rd_rdata got %h exp 12345678", bus.resp_rdata); else passed++;
        checks++; if (bus.resp_err !== 3'd0) $display("FAIL rd_err got %0d exp 0", bus.resp_err); else passed++;
        checks++; if (bus.next_regno !== 16'h1005) $display("FAIL rd_next_regno got %h exp 1005", bus.next_regno); else passed++;
        step();
        checks++; if (re_cnt - r0 !== 1) $display("FAIL rd_pulse_count got %0d exp 1", re_cnt - r0); else passed++;
    endtask

    task automatic test_not_halted();
        int r0, w0;
        r0 = re_cnt;
        w0 = we_cnt;
        core_halted = 1'b0;
        issue(1'b0, 16'h1001, 32'h0, 1'b0);
        checks++; if (bus.resp_valid !== 1'b1) $display("FAIL nh_resp_valid got %b exp 1 at N+1", bus.resp_valid); else passed++;
        checks++; if (bus.resp_err !== 3'd4 || bus.resp_rdata !== 32'h0) $display("FAIL nh_resp got err=%0d rdata=%h exp err=4 rdata=0", bus.resp_err, bus.resp_rdata); else passed++;
        step();
        core_halted = 1'b1;
        checks++; if (re_cnt != r0 || we_cnt != w0) $display("FAIL nh_no_strobe got re=%0d we=%0d exp 0/0", re_cnt - r0, we_cnt - w0); else passed++;
    endtask

    task automatic test_bad_regno();
        int r0, w0;
        r0 = re_cnt;
        w0 = we_cnt;
        issue(1'b0, 16'h1020, 32'h0, 1'b0);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 3'd2) $display("FAIL bad_1020 got valid=%b err=%0d exp 1/2", bus.resp_valid, bus.resp_err); else passed++;
        step();
        issue(1'b1, 16'h0300, 32'h5555_AAAA, 1'b0);
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 3'd2) $display("FAIL bad_0300 got valid=%b err=%0d exp 1/2", bus.resp_valid, bus.resp_err); else passed++;
        step();
        checks++; if (re_cnt != r0 || we_cnt != w0) $display("FAIL bad_no_strobe got re=%0d we=%0d exp 0/0", re_cnt - r0, we_cnt - w0); else passed++;
        checks++; if (rf_addr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) $display("FAIL bad_rf_hold got addr=%0d wdata=%h exp 5/deadbeef", rf_addr, rf_wdata); else passed++;
    endtask

    task automatic test_x0();
        int w0;
        w0 = we_cnt;
        issue(1'b1, 16'h1000, 32'h0000_1234, 1'b0);
        checks++; if (rf_we !== 1'b0) $display("FAIL x0_wr_we got %b exp 0", rf_we); else passed++;
        step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 3'd0) $display("FAIL x0_wr_resp got valid=%b err=%0d exp 1/0", bus.resp_valid, bus.resp_err); else passed++;
        step();
        checks++; if (we_cnt != w0) $display("FAIL x0_wr_count got %0d exp 0", we_cnt - w0); else passed++;
        issue(1'b0, 16'h1000, 32'h0, 1'b0);
        repeat (4) step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 3'd0) $display("FAIL x0_rd got valid=%b rdata=%h err=%0d exp 1/0/0", bus.resp_valid, bus.resp_rdata, bus.resp_err); else passed++;
        step();
    endtask

    task automatic test_backpressure();
        int r0;
        bus.resp_ready = 1'b0;
        issue(1'b0, 16'h1005, 32'h0, 1'b0);
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1234_5678 || bus.resp_err !== 3'd0 || bus.req_ready !== 1'b0)
                $display("FAIL bp_hold_%0d got valid=%b rdata=%h err=%0d ready=%b exp 1/12345678/0/0", i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
            else passed++;
            step();
        end
        bus.resp_ready = 1'b1;
        checks++; if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) $display("FAIL bp_hs_cycle got ready=%b valid=%b exp 0/1", bus.req_ready, bus.resp_valid); else passed++;
        step();
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL bp_after_hs got ready=%b valid=%b exp 1/0", bus.req_ready, bus.resp_valid); else passed++;
        r0 = re_cnt;
        issue(1'b0, 16'h1005, 32'h0, 1'b0);
        step();
        core_halted = 1'b0;
        step();
        core_halted = 1'b1;
        repeat (2) step();
        checks++; if (bus.resp_valid !== 1'b1) $display("FAIL hd_resp_valid got %b exp 1 at N+5", bus.resp_valid); else passed++;
        checks++; if (bus.resp_err !== 3'd4 || bus.resp_rdata !== 32'h0) $display("FAIL hd_resp got err=%0d rdata=%h exp err=4 rdata=0", bus.resp_err, bus.resp_rdata); else passed++;
        step();
        checks++; if (re_cnt - r0 !== 1) $display("FAIL hd_pulse_count got %0d exp 1", re_cnt - r0); else passed++;
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = we_cnt;
        bus.req_write   = 1'b1;
        bus.req_regno   = 16'h1007;
        bus.req_wdata   = 32'hA5A5_A5A5;
        bus.req_postinc = 1'b0;
        bus.req_valid   = 1'b1;
        repeat (9) step();
        bus.req_valid   = 1'b0;
        checks++; if (we_cnt - w0 !== 3) $display("FAIL b2b_writes got %0d exp 3 in 9 cycles", we_cnt - w0); else passed++;
        checks++; if (we_addr !== 5'd7 || we_data !== 32'hA5A5_A5A5) $display("FAIL b2b_target got addr=%0d data=%h exp 7/a5a5a5a5", we_addr, we_data); else passed++;
        checks++; if (bus.req_ready !== 1'b1) $display("FAIL b2b_idle got %b exp 1", bus.req_ready); else passed++;
    endtask

    task automatic test_postinc();
        logic [15:0] exp_next;
`ifdef REGBRIDGE_POSTINC_EN
        exp_next = 16'h1020;
`else
        exp_next = 16'h101F;
`endif
        issue(1'b0, 16'h101F, 32'h0, 1'b1);
        repeat (4) step();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h3131_3131) $display("FAIL pi_rd got valid=%b rdata=%h exp 1/31313131", bus.resp_valid, bus.resp_rdata); else passed++;
        checks++; if (bus.next_regno !== exp_next) $display("FAIL pi_next_101f got %h exp %h", bus.next_regno, exp_next); else passed++;
        step();
        issue(1'b0, 16'h1020, 32'h0, 1'b1);
        checks++; if (bus.resp_err !== 3'd2 || bus.next_regno !== 16'h1020) $display("FAIL pi_1020 got err=%0d next=%h exp 2/1020", bus.resp_err, bus.next_regno); else passed++;
        step();
        issue(1'b0, 16'hFFFF, 32'h0, 1'b1);
        checks++; if (bus.resp_err !== 3'd2 || bus.next_regno !== 16'hFFFF) $display("FAIL pi_ffff got err=%0d next=%h exp 2/ffff", bus.resp_err, bus.next_regno); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = we_cnt;
        issue(1'b1, 16'h1009, 32'h0000_0077, 1'b0);
        checks++; if (rf_we !== 1'b1) $display("FAIL rm_pulse_start got %b exp 1", rf_we); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL rm_outputs got we=%b ready=%b valid=%b exp 0/1/0", rf_we, bus.req_ready, bus.resp_valid); else passed++;
        checks++; if (rf_addr !== 5'd0 || rf_wdata !== 32'h0 || bus.next_regno !== 16'h1000) $display("FAIL rm_regs got addr=%0d wdata=%h next=%h exp 0/0/1000", rf_addr, rf_wdata, bus.next_regno); else passed++;
        step();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (bus.resp_valid !== 1'b0 || we_cnt != w0) $display("FAIL rm_no_resp got valid=%b writes=%0d exp 0/0", bus.resp_valid, we_cnt - w0); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'hCAFE_0000 | i;
        rf_mem[0]  = 32'hFFFF_FFFF;
        rf_mem[5]  = 32'h1234_5678;
        rf_mem[31] = 32'h3131_3131;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_regno   = 16'h0;
        bus.req_wdata   = 32'h0;
        bus.req_postinc = 1'b0;
        bus.resp_ready  = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_not_halted();
        test_bad_regno();
        test_x0();
        test_backpressure();
        test_back_to_back();
        test_postinc();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
